// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared definitions for the store path: store_ctrl encodings,
//                store engine state enum, read-latency counter width and the
//                request fault check.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // store_ctrl encodings
  localparam logic [1:0] ST_SW  = 2'b00;
  localparam logic [1:0] ST_SH  = 2'b01;
  localparam logic [1:0] ST_SB  = 2'b10;
  localparam logic [1:0] ST_INV = 2'b11;

  // Width of the memory read latency counter (RD_LAT up to 7)
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } storeState_t;

  // A request is rejected when the encoding is invalid or the access is
  // misaligned for its size (bytes can never be misaligned).
  function automatic logic isStoreFault(input logic [1:0] ctrl,
                                        input logic [1:0] byteOff);
    logic f;
    f = 1'b0;
    if (ctrl == ST_INV)                        f = 1'b1;
    if ((ctrl == ST_SW) && (byteOff != 2'b00)) f = 1'b1;
    if ((ctrl == ST_SH) && byteOff[0])         f = 1'b1;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : byte_lane_merge
//  Description : Combinational little-endian lane merge. Inserts the low
//                byte/half of the store data into the old memory word at the
//                lane selected by the byte offset; all other lanes pass
//                through unchanged.
//  Ports       : oldWord   - word read from memory
//                wdata     - store data (low bits used for sh/sb)
//                storeCtrl - sw/sh/sb/invalid
//                byteOff   - addr[1:0] of the store
//                merged    - word to be written back
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_merge
  import cpu_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] wdata,
  input  logic [1:0]  storeCtrl,
  input  logic [1:0]  byteOff,
  output logic [31:0] merged
);

  always_comb begin
    merged = oldWord;
    case (storeCtrl)
      ST_SW: merged = wdata;
      ST_SH: begin
        if (byteOff[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      ST_SB: begin
        case (byteOff)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = oldWord;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_rmw_unit.sv
`default_nettype none
// ============================================================================
//  Module      : store_rmw_unit
//  Description : Multicycle store engine. sw writes directly; sh/sb read the
//                target word, merge the new lane(s) and write the whole word
//                back so untouched bytes are preserved. Misaligned or invalid
//                requests complete with fault and never write.
//  Ports       : clk, reset        - clock, async active-high reset
//                start             - request strobe (sampled in IDLE only)
//                store_ctrl        - 00 sw, 01 sh, 10 sb, 11 invalid
//                addr, wdata       - byte address and register data
//                mem_rdata         - memory read data (RD_LAT cycles)
//                mem_addr          - word-aligned memory address
//                mem_wr, mem_wdata - one-cycle write strobe and data
//                busy, done, fault - status to the control FSM
//  Revision    : 1.0 - initial release
// ============================================================================
module store_rmw_unit
  import cpu_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int AW     = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    store_ctrl,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [31:0]   mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          fault
);

  localparam logic [LAT_CNT_W-1:0] c_LAST_CNT = LAT_CNT_W'(RD_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] c_CNT_ONE  = LAT_CNT_W'(1);

  storeState_t r_state;
  storeState_t w_nextState;

  logic [1:0]           r_ctrl;
  logic [1:0]           r_byteOff;
  logic [31:0]          r_wdata;
  logic [AW-1:0]        r_memAddr;
  // Captured write word: wdata for sw, the merged read word for sh/sb.
  logic [31:0]          r_capWord;
  logic                 r_fault;
  logic [LAT_CNT_W-1:0] r_cnt;

  logic                 w_accept;
  logic                 w_reqFault;
  logic                 w_readDone;
  logic [31:0]          w_merged;

  assign w_accept   = (r_state == IDLE) && start;
  assign w_reqFault = isStoreFault(store_ctrl, addr[1:0]);
  assign w_readDone = (r_cnt == c_LAST_CNT);

  byte_lane_merge u_merge (
    .oldWord   (mem_rdata),
    .wdata     (r_wdata),
    .storeCtrl (r_ctrl),
    .byteOff   (r_byteOff),
    .merged    (w_merged)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_reqFault)               w_nextState = DONE;
          else if (store_ctrl == ST_SW) w_nextState = WRITE;
          else                          w_nextState = READ;
        end
      end
      READ:    if (w_readDone) w_nextState = WRITE;
      WRITE:   w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Request capture, latency counter and merge capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl    <= ST_SW;
      r_byteOff <= 2'b00;
      r_wdata   <= 32'd0;
      r_memAddr <= '0;
      r_capWord <= 32'd0;
      r_fault   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_ctrl    <= store_ctrl;
        r_byteOff <= addr[1:0];
        r_wdata   <= wdata;
        r_memAddr <= {addr[AW-1:2], 2'b00};
        r_fault   <= w_reqFault;
        r_cnt     <= '0;
        if (store_ctrl == ST_SW) r_capWord <= wdata;
      end else if (r_state == READ) begin
        // mem_addr has been stable for RD_LAT cycles on the edge that
        // leaves READ, so mem_rdata is sampled and merged right then.
        if (w_readDone) r_capWord <= w_merged;
        else            r_cnt     <= r_cnt + c_CNT_ONE;
      end
    end
  end

  // Strobes are decoded from the state so reset removes them immediately.
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_capWord;
  assign mem_wr    = (r_state == WRITE) && !r_fault;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign fault     = (r_state == DONE) && r_fault;

endmodule
`default_nettype wire

// File: tb/tb_store_rmw_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_rmw_unit
//  Description : Directed self-checking bench for store_rmw_unit with a
//                single-word memory model that only returns valid data once
//                mem_addr has been held for RD_LAT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_rmw_unit;

  localparam int RD_LAT = 2;
  localparam int AW     = 32;

  logic          clk;
  logic          reset;
  logic          start;
  logic [1:0]    store_ctrl;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic          fault;

  int            nAsserts;
  int            nFail;
  int            writeCount;
  int            stableCyc;
  logic [31:0]   oldWord;

  store_rmw_unit #(.RD_LAT(RD_LAT), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .store_ctrl (store_ctrl),
    .addr       (addr),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: read data is garbage until the address has been stable
  // for the full read latency of the current operation.
  always @(posedge clk) begin
    if (!busy) stableCyc <= 0;
    else       stableCyc <= stableCyc + 1;
    if (mem_wr === 1'b1) writeCount <= writeCount + 1;
  end

  assign mem_rdata = (busy && (stableCyc >= RD_LAT - 1)) ? oldWord : 32'hBAD0BAD0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and check every cycle up to one cycle past done.
  // wrK = cycle of the write (0 = no write), doneK = cycle of done,
  // glitchK = cycle in which a spurious start with other operands is driven.
  task automatic runReq(input string name, input logic [1:0] ctrl, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] oldW, input int wrK,
                        input int doneK, input logic [31:0] expAddr,
                        input logic [31:0] expData, input logic expFault, input int glitchK);
    int wc0;
    oldWord = oldW;
    wc0 = writeCount;
    @(negedge clk);
    start = 1'b1; store_ctrl = ctrl; addr = a; wdata = d;
    for (int k = 1; k <= doneK + 1; k++) begin
      @(negedge clk);
      start      = (k == glitchK);
      store_ctrl = 2'b00;
      addr       = 32'h0000_0200 + 32'(k * 4);
      wdata      = 32'hFFFF_FFFF;
      check({name, ".mem_wr"}, {31'd0, mem_wr}, {31'd0, (k == wrK)});
      if (k == wrK) begin
        check({name, ".mem_addr"}, mem_addr, expAddr);
        check({name, ".mem_wdata"}, mem_wdata, expData);
      end
      check({name, ".done"}, {31'd0, done}, {31'd0, (k == doneK)});
      check({name, ".busy"}, {31'd0, busy}, {31'd0, (k <= doneK)});
      if (k == doneK) check({name, ".fault"}, {31'd0, fault}, {31'd0, expFault});
    end
    check({name, ".writes"}, 32'(writeCount - wc0), (wrK != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int wc0;
    nAsserts   = 0;
    nFail      = 0;
    writeCount = 0;
    stableCyc  = 0;
    oldWord    = 32'h0;
    reset      = 1'b1;
    start      = 1'b0;
    store_ctrl = 2'b00;
    addr       = 32'h0;
    wdata      = 32'h0;

    repeat (3) @(negedge clk);
    check("rst.mem_addr", mem_addr, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.ctl", {28'd0, mem_wr, busy, done, fault}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // sw: direct write in T+1, done in T+2
    runReq("sw100", 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1122_3344,
           1, 2, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 0);
    // sb lane 3
    runReq("sb103", 2'b10, 32'h0000_0103, 32'h0000_00AB, 32'h1122_3344,
           3, 4, 32'h0000_0100, 32'hAB22_3344, 1'b0, 0);
    // sh upper / lower half
    runReq("sh102", 2'b01, 32'h0000_0102, 32'h1234_BEEF, 32'h1122_3344,
           3, 4, 32'h0000_0100, 32'hBEEF_3344, 1'b0, 0);
    runReq("sh100", 2'b01, 32'h0000_0100, 32'h1234_BEEF, 32'h1122_3344,
           3, 4, 32'h0000_0100, 32'h1122_BEEF, 1'b0, 0);
    // Faults: done in T+1, no write
    runReq("fSh101", 2'b01, 32'h0000_0101, 32'h1234_BEEF, 32'h1122_3344,
           0, 1, 32'h0, 32'h0, 1'b1, 0);
    runReq("fSw102", 2'b00, 32'h0000_0102, 32'hDEAD_BEEF, 32'h1122_3344,
           0, 1, 32'h0, 32'h0, 1'b1, 0);
    runReq("fInv", 2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 32'h1122_3344,
           0, 1, 32'h0, 32'h0, 1'b1, 0);
    // start during READ and during DONE is ignored
    runReq("sbGlR", 2'b10, 32'h0000_0101, 32'h0000_0055, 32'h1122_3344,
           3, 4, 32'h0000_0100, 32'h1122_5544, 1'b0, 1);
    runReq("sbGlD", 2'b10, 32'h0000_0102, 32'h0000_0077, 32'h1122_3344,
           3, 4, 32'h0000_0100, 32'h1177_3344, 1'b0, 4);

    // Reset in the second READ cycle aborts with no write
    oldWord = 32'h1122_3344;
    wc0 = writeCount;
    @(negedge clk);
    start = 1'b1; store_ctrl = 2'b10; addr = 32'h0000_0100; wdata = 32'h0000_00CC;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rstMid.busyBefore", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstMid.mem_addr", mem_addr, 32'h0);
    check("rstMid.mem_wdata", mem_wdata, 32'h0);
    check("rstMid.ctl", {28'd0, mem_wr, busy, done, fault}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rstMid.writes", 32'(writeCount - wc0), 32'd0);
    check("rstMid.idle", {31'd0, busy}, 32'd0);

    runReq("swPost", 2'b00, 32'h0000_0104, 32'h0BAD_F00D, 32'h1122_3344,
           1, 2, 32'h0000_0104, 32'h0BAD_F00D, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
Multicycle store engine; the writer-side counterpart of the load-path byte/half extractor.
- Takes a store request from the control FSM (sw/sh/sb, byte address, register data).
- Drives the word-addressed data memory port.
- sh/sb: read-modify-write so untouched byte lanes are preserved. sw: direct write.
- Sits between the B register / ALUOut datapath and the memory write port. Signals completion to the control FSM with a one-cycle done pulse.

Parameters:
- RD_LAT, 2, memory read latency in cycles from stable mem_addr to valid mem_rdata (legal 1..7).
- AW, 32, address width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request strobe, sampled only in IDLE.
- store_ctrl  input  2  00=sw, 01=sh, 10=sb, 11=invalid.
- addr  input  AW  byte address of the store.
- wdata  input  32  register data; low bits are used for sh/sb.
- mem_rdata  input  32  memory read data.
- mem_addr  output  AW  word-aligned memory address.
- mem_wr  output  1  memory write enable, one cycle.
- mem_wdata  output  32  word to write.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- fault  output  1  valid with done; 1 means the request was rejected and no write occurred.

Behaviour:
- Reset (async, immediate): state=IDLE.
  - mem_addr, mem_wdata, and the internal captured word return to 0.
  - mem_wr, busy, done, fault return to 0.
  - The latency counter returns to 0.
- Request capture: start=1 in IDLE latches addr, store_ctrl, wdata. Later changes to these inputs are ignored until return to IDLE.
- mem_addr = {addr[AW-1:2], 2'b00}. It is registered at capture and held stable until IDLE.
- Byte ordering is little-endian: offset 0 = bits[7:0] and offset 3 = bits[31:24].
- Fault check at capture:
  - store_ctrl=11 is a fault.
  - sw with addr[1:0]!=0 is a fault.
  - sh with addr[0]=1 is a fault.
  - Any fault goes to DONE with fault=1. mem_wr is never asserted.
- States:
  - IDLE: start → READ (sh/sb), WRITE (sw), or DONE (fault).
  - READ: held for RD_LAT cycles by the counter. On the edge leaving READ, mem_rdata is captured and the merged word is registered into mem_wdata. Next state is WRITE.
  - WRITE: mem_wr=1 for exactly one cycle. For sw, mem_wdata=wdata. Next state is DONE.
  - DONE: done=1 for one cycle; fault is valid. Next state is IDLE.
- Merge rules:
  - sb: replace lane addr[1:0] with wdata[7:0].
  - sh: addr[1]=0 replaces [15:0], addr[1]=1 replaces [31:16], each with wdata[15:0].
  - All other lanes come from the captured word.
- Latency, with start sampled at edge T:
  - sw: WRITE in cycle T+1, done in cycle T+2.
  - sh/sb: WRITE in cycle T+RD_LAT+1, done in cycle T+RD_LAT+2.
  - fault: done in cycle T+1.
- start while busy: ignored, not queued.
- start in the DONE cycle: ignored. A new request is accepted no earlier than the cycle after done.
- Reset mid-operation: aborts with no partial write. If reset is asserted during WRITE, mem_wr drops asynchronously.
- mem_wr is never high outside WRITE. done is never high for two consecutive cycles.

Decomposition:
- Shared package (cpu_pkg) holds:
  - store_ctrl encodings: ST_SW, ST_SH, ST_SB, ST_INV.
  - State enum: IDLE, READ, WRITE, DONE.
  - The 3-bit latency counter width.
- One sub-module: byte_lane_merge, purely combinational. Inputs: old word, wdata, store_ctrl, addr[1:0]. Output: merged word. It is shared with the load path's lane logic conventions.

Test Plan:
- sw at addr 0x00000100 with wdata 0xDEADBEEF → mem_wr in T+1 at mem_addr 0x100 with data 0xDEADBEEF; done in T+2; fault=0; no read wait.
- sb at addr 0x103 with wdata 0x000000AB and memory holding 0x11223344, RD_LAT=2 → single write of 0xAB223344 to 0x100 in T+3; done in T+4.
- sh at addr 0x102 with wdata 0x1234BEEF and old word 0x11223344 → write 0xBEEF3344. Same for sh at 0x100 → 0x1122BEEF.
- Faults: sh at 0x101, sw at 0x102, and store_ctrl=11 → done in T+1 with fault=1; mem_wr stays 0 throughout.
- start pulsed with new addr/data during READ of an sb → ignored; only the original write occurs; busy stays high until done.
- reset asserted in the second READ cycle → all outputs 0 immediately, no mem_wr ever; a new sw issued after reset release completes normally in 2 cycles.
